// File: rtl/token_lexer_if.sv
// Byte-in / token-out handshake bundle for token_lexer.
// master drives bytes and pops tokens; slave is the lexer.
interface token_lexer_if #(parameter int NUM_W = 8);
  logic             I_VALID;
  logic             I_READY;
  logic [7:0]       I_DATA;
  logic             O_VALID;
  logic             O_READY;
  logic [7:0]       O_KIND;
  logic [NUM_W-1:0] O_VALUE;

  modport master (
    output I_VALID, I_DATA, O_READY,
    input  I_READY, O_VALID, O_KIND, O_VALUE
  );

  modport slave (
    input  I_VALID, I_DATA, O_READY,
    output I_READY, O_VALID, O_KIND, O_VALUE
  );
endinterface

// File: rtl/token_lexer.sv
// Streaming ASCII lexer producing (kind, value) tokens through a small output FIFO.
// Define LEXER_HEX_EN to accept "0x" prefixed hexadecimal numbers.
//
// state  | meaning
// S_IDLE | between tokens, skipping delimiters
// S_NUM  | accumulating a decimal (or hex) number
// S_WORD | collecting word chars into the buffer
// S_BAD  | token already known to be UNKNOWN, absorbing to terminator
// S_PEND | terminating punct still has to be pushed
// S_EOF  | EOF pushed, input closed until RST
module token_lexer #(
  parameter int MAX_LEN    = 8,
  parameter int NUM_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  token_lexer_if.slave bus,
  output logic         FOUND_EOF
);
  typedef enum logic [2:0] {S_IDLE, S_NUM, S_WORD, S_BAD, S_PEND, S_EOF} state_t;

  localparam logic [7:0] K_NUM = 8'h00, K_OUT = 8'h01, K_VAR_A = 8'h02, K_EQUAL = 8'h03;
  localparam logic [7:0] K_VAR_B = 8'h04, K_VAR_C = 8'h05, K_IF = 8'h06, K_LP = 8'h07;
  localparam logic [7:0] K_RP = 8'h08, K_PLUS = 8'h09, K_MINUS = 8'h0A, K_SEMI = 8'h0B;
  localparam logic [7:0] K_EOF = 8'h0C, K_UNK = 8'hFF;

  localparam int ACC_W = NUM_W + 4;
  localparam int BUF_W = MAX_LEN * 8;
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ACC_W-1:0] MAX_VAL = {4'b0, {NUM_W{1'b1}}};
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_calc;
  logic [BUF_W-1:0] wbuf, wbuf_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [7:0]       pend_kind, pend_nxt;
  logic             found_eof_q, eof_set;

  logic [7:0]       fifo_kind [FIFO_DEPTH];
  logic [NUM_W-1:0] fifo_val  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, xfer, pop, push;
  logic [7:0]       push_kind;
  logic [NUM_W-1:0] push_val;

  logic [7:0]       c, punct_kind, word_kind, term_kind;
  logic [NUM_W-1:0] term_val;
  logic [3:0]       dval;
  logic             is_delim, is_punct, is_digit, num_digit, hex_switch;
`ifdef LEXER_HEX_EN
  logic             hex, hex_nxt, is_hex_digit;
`endif

  assign c        = bus.I_DATA;
  assign is_delim = c inside {8'h09, 8'h0A, 8'h0D, 8'h20, 8'h00, 8'hFF};
  assign is_digit = (c >= 8'h30) && (c <= 8'h39);
  // letters a-f / A-F carry value-9 in their low nibble
  assign dval     = (c >= 8'h41) ? c[3:0] + 4'd9 : c[3:0];
`ifdef LEXER_HEX_EN
  assign is_hex_digit = is_digit || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
`endif

  always_comb begin
    punct_kind = K_UNK;
    is_punct   = 1'b1;
    case (c)
      8'h28:   punct_kind = K_LP;
      8'h29:   punct_kind = K_RP;
      8'h3D:   punct_kind = K_EQUAL;
      8'h2B:   punct_kind = K_PLUS;
      8'h2D:   punct_kind = K_MINUS;
      8'h3B:   punct_kind = K_SEMI;
      default: is_punct = 1'b0;
    endcase
  end

  // buffer holds the most recent chars, first char in the highest used byte
  always_comb begin
    word_kind = K_UNK;
    if (len == LEN_W'(1) && wbuf[7:0] == 8'h61) word_kind = K_VAR_A;
    else if (len == LEN_W'(1) && wbuf[7:0] == 8'h62) word_kind = K_VAR_B;
    else if (len == LEN_W'(1) && wbuf[7:0] == 8'h63) word_kind = K_VAR_C;
    else if (len == LEN_W'(2) && wbuf[15:0] == 16'h6966) word_kind = K_IF;
    else if (len == LEN_W'(3) && wbuf[23:0] == 24'h6F7574) word_kind = K_OUT;
    else if (len == LEN_W'(3) && wbuf[23:0] == 24'h454F46) word_kind = K_EOF;
  end

  always_comb begin
    term_kind = K_UNK;
    term_val  = '0;
    if (state == S_NUM) begin
      term_kind = K_NUM;
      term_val  = acc[NUM_W-1:0];
`ifdef LEXER_HEX_EN
      if (hex && len == '0) begin
        term_kind = K_UNK;
        term_val  = '0;
      end
`endif
    end else if (state == S_WORD) begin
      term_kind = word_kind;
    end
  end

  assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign bus.I_READY = !RST && state != S_PEND && state != S_EOF && !full;
  assign xfer        = bus.I_VALID && bus.I_READY;
  assign bus.O_VALID = !RST && count != '0;
  assign pop         = bus.O_VALID && bus.O_READY;
  assign bus.O_KIND  = bus.O_VALID ? fifo_kind[rd_ptr] : 8'h00;
  assign bus.O_VALUE = bus.O_VALID ? fifo_val[rd_ptr] : '0;
  assign FOUND_EOF   = !RST && found_eof_q;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    wbuf_nxt   = wbuf;
    len_nxt    = len;
    pend_nxt   = pend_kind;
    push       = 1'b0;
    push_kind  = K_NUM;
    push_val   = '0;
    eof_set    = 1'b0;
    hex_switch = 1'b0;
    num_digit  = is_digit;
`ifdef LEXER_HEX_EN
    hex_nxt    = hex;
    hex_switch = !hex && acc == '0 && len == LEN_W'(1) && c == 8'h78;
    if (hex) num_digit = is_hex_digit;
    acc_calc   = hex ? (acc << 4) + ACC_W'(dval) : (acc << 3) + (acc << 1) + ACC_W'(dval);
`else
    acc_calc   = (acc << 3) + (acc << 1) + ACC_W'(dval);
`endif
    case (state)
      S_PEND: begin
        if (!full) begin
          push      = 1'b1;
          push_kind = pend_kind;
          state_nxt = S_IDLE;
        end
      end
      S_EOF: ;
      default: begin
        if (xfer) begin
          if ((is_delim || is_punct) && state != S_IDLE) begin
            push      = 1'b1;
            push_kind = term_kind;
            push_val  = term_val;
            if (term_kind == K_EOF) begin
              eof_set   = 1'b1;
              state_nxt = S_EOF;
            end else if (is_punct) begin
              pend_nxt  = punct_kind;
              state_nxt = S_PEND;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            case (state)
              S_IDLE: begin
                if (is_punct) begin
                  push      = 1'b1;
                  push_kind = punct_kind;
                end else if (is_digit) begin
                  acc_nxt   = ACC_W'(dval);
                  len_nxt   = LEN_W'(1);
                  state_nxt = S_NUM;
`ifdef LEXER_HEX_EN
                  hex_nxt   = 1'b0;
`endif
                end else if (!is_delim) begin
                  wbuf_nxt  = {{(BUF_W-8){1'b0}}, c};
                  len_nxt   = LEN_W'(1);
                  state_nxt = S_WORD;
                end
              end
              S_NUM: begin
                if (hex_switch) begin
`ifdef LEXER_HEX_EN
                  hex_nxt = 1'b1;
`endif
                  len_nxt = '0;
                end else if (num_digit && acc_calc <= MAX_VAL) begin
                  acc_nxt = acc_calc;
                  if (len != LEN_SAT) len_nxt = len + LEN_W'(1);
                end else begin
                  state_nxt = S_BAD;
                end
              end
              S_WORD: begin
                wbuf_nxt = {wbuf[BUF_W-9:0], c};
                if (len != LEN_SAT) len_nxt = len + LEN_W'(1);
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      acc         <= '0;
      wbuf        <= '0;
      len         <= '0;
      pend_kind   <= 8'h00;
      found_eof_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
`ifdef LEXER_HEX_EN
      hex         <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      wbuf      <= wbuf_nxt;
      len       <= len_nxt;
      pend_kind <= pend_nxt;
`ifdef LEXER_HEX_EN
      hex       <= hex_nxt;
`endif
      if (eof_set) found_eof_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_kind[wr_ptr] <= push_kind;
      fifo_val[wr_ptr]  <= push_val;
    end
  end
endmodule

// File: tb/tb_token_lexer.sv
// Self-checking bench for token_lexer: directed scenarios plus random streams
// compared against a tokenize-then-classify reference model.
module tb_token_lexer;
  typedef logic [7:0]  ch_t;
  typedef logic [15:0] tok_t;

  localparam int MAX_LEN = 8;
  localparam int DEPTH   = 4;
  localparam int MAXV    = 255;

  logic CLK = 1'b0;
  logic RST;
  logic found_eof;
  int   checks = 0;
  int   errors = 0;
  bit   rdy_rand = 1'b0;
  tok_t got_q[$];

  token_lexer_if #(.NUM_W(8)) bus ();

  token_lexer #(.MAX_LEN(MAX_LEN), .NUM_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .FOUND_EOF(found_eof)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (bus.O_VALID && bus.O_READY) got_q.push_back({bus.O_KIND, bus.O_VALUE});

  always @(posedge CLK) begin
    #2;
    if (rdy_rand) bus.O_READY = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic tok_t tok(input logic [7:0] k, input int v);
    return {k, v[7:0]};
  endfunction

  function automatic bit is_dig(input ch_t ch);
    return ch >= 8'h30 && ch <= 8'h39;
  endfunction

  function automatic int hexval(input ch_t ch);
    if (is_dig(ch)) return ch - 48;
    if (ch >= 8'h61 && ch <= 8'h66) return ch - 87;
    if (ch >= 8'h41 && ch <= 8'h46) return ch - 55;
    return -1;
  endfunction

  function automatic int punct_of(input ch_t ch);
    case (ch)
      8'h28: return 8'h07;
      8'h29: return 8'h08;
      8'h3D: return 8'h03;
      8'h2B: return 8'h09;
      8'h2D: return 8'h0A;
      8'h3B: return 8'h0B;
      default: return -1;
    endcase
  endfunction

  function automatic tok_t classify(input ch_t w[$]);
    int v;
    string t;
    if (is_dig(w[0])) begin
`ifdef LEXER_HEX_EN
      if (w.size() >= 2 && w[0] == 8'h30 && w[1] == 8'h78) begin
        if (w.size() == 2) return tok(8'hFF, 0);
        v = 0;
        for (int j = 2; j < w.size(); j++) begin
          if (hexval(w[j]) < 0) return tok(8'hFF, 0);
          v = v * 16 + hexval(w[j]);
          if (v > MAXV) return tok(8'hFF, 0);
        end
        return tok(8'h00, v);
      end
`endif
      v = 0;
      foreach (w[j]) begin
        if (!is_dig(w[j])) return tok(8'hFF, 0);
        v = v * 10 + (w[j] - 48);
        if (v > MAXV) return tok(8'hFF, 0);
      end
      return tok(8'h00, v);
    end
    if (w.size() > MAX_LEN) return tok(8'hFF, 0);
    t = "";
    foreach (w[j]) t = $sformatf("%s%c", t, w[j]);
    if (t == "a")   return tok(8'h02, 0);
    if (t == "b")   return tok(8'h04, 0);
    if (t == "c")   return tok(8'h05, 0);
    if (t == "if")  return tok(8'h06, 0);
    if (t == "out") return tok(8'h01, 0);
    if (t == "EOF") return tok(8'h0C, 0);
    return tok(8'hFF, 0);
  endfunction

  // split on delimiters and punctuation, classify each word, stop after EOF
  function automatic void model(input ch_t s[$], output tok_t q[$]);
    ch_t w[$];
    tok_t k;
    q = {};
    foreach (s[i]) begin
      if (s[i] inside {8'h09, 8'h0A, 8'h0D, 8'h20, 8'h00, 8'hFF} || punct_of(s[i]) >= 0) begin
        if (w.size() > 0) begin
          k = classify(w);
          q.push_back(k);
          w = {};
          if (k[15:8] == 8'h0C) return;
        end
        if (punct_of(s[i]) >= 0) q.push_back(tok(8'(punct_of(s[i])), 0));
      end else begin
        w.push_back(s[i]);
      end
    end
  endfunction

  function automatic void s2b(input string s, output ch_t q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bytes(input ch_t b[$], input int budget, output int stalls[$], output bit all_ok);
    stalls = {};
    all_ok = 1'b1;
    foreach (b[i]) begin
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      bus.I_VALID = 1'b1;
      bus.I_DATA  = b[i];
      while (!acc && n < budget) begin
        @(negedge CLK);
        acc = bus.I_READY;
        @(posedge CLK);
        #1;
        n++;
      end
      stalls.push_back(n - 1);
      if (!acc) begin
        all_ok = 1'b0;
        break;
      end
    end
    bus.I_VALID = 1'b0;
  endtask

  task automatic send_str(input string s, input int budget, output bit ok);
    ch_t b[$];
    int st[$];
    s2b(s, b);
    send_bytes(b, budget, st, ok);
  endtask

  task automatic check_tokens(input string tag, input tok_t exp[$]);
    int n;
    n = 0;
    while (got_q.size() < exp.size() && n < 600) begin
      @(posedge CLK);
      #1;
      n++;
    end
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    chk({tag, " count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s tok%0d", tag, i), got_q[i], exp[i]);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit   ok;
    ch_t  b[$];
    int   st[$];
    tok_t exp[$];
    string wl[9] = '{"a", "b", "c", "if", "out", "xyz", "abcdefghij", "if2", "iff"};
    string ps = "()=+-;";
    string oc = "0x9zAfq";
    ch_t  dl[6] = '{8'h09, 8'h0A, 8'h0D, 8'h20, 8'h00, 8'hFF};
    string piece;

    RST = 1'b1;
    bus.I_VALID = 1'b0;
    bus.I_DATA  = 8'h00;
    bus.O_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst O_VALID", bus.O_VALID, 0);
    chk("rst O_KIND", bus.O_KIND, 0);
    chk("rst O_VALUE", bus.O_VALUE, 0);
    chk("rst FOUND_EOF", found_eof, 0);
    chk("rst I_READY", bus.I_READY, 0);
    RST = 1'b0;
    bus.O_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("post-rst I_READY", bus.I_READY, 1);

    // assignment statement; ';' terminating a number costs one stall cycle
    got_q = {};
    s2b("a = 12;\n", b);
    send_bytes(b, 200, st, ok);
    chk("assign accepted", ok, 1);
    chk("assign nl stall", st[7], 1);
    exp = '{tok(8'h02, 0), tok(8'h03, 0), tok(8'h00, 12), tok(8'h0B, 0)};
    check_tokens("assign", exp);

    got_q = {};
    s2b("if(b) ", b);
    send_bytes(b, 200, st, ok);
    chk("if accepted", ok, 1);
    chk("if lp stall", st[2], 0);
    chk("if b stall", st[3], 1);
    chk("if sp stall", st[5], 1);
    exp = '{tok(8'h06, 0), tok(8'h07, 0), tok(8'h04, 0), tok(8'h08, 0)};
    check_tokens("if", exp);

    got_q = {};
    send_str("255 256 abcdefghi 9z ", 200, ok);
    exp = '{tok(8'h00, 255), tok(8'hFF, 0), tok(8'hFF, 0), tok(8'hFF, 0)};
    check_tokens("bounds", exp);

    got_q = {};
    send_str("0x1F ", 200, ok);
`ifdef LEXER_HEX_EN
    exp = '{tok(8'h00, 31)};
`else
    exp = '{tok(8'hFF, 0)};
`endif
    check_tokens("hex", exp);

    // backpressure: FIFO fills after four tokens
    got_q = {};
    bus.O_READY = 1'b0;
    send_str("a ", 200, ok);
    chk("latency O_VALID", bus.O_VALID, 1);
    send_str("a a a ", 200, ok);
    chk("full I_READY", bus.I_READY, 0);
    send_str("a", 10, ok);
    chk("full blocked", ok, 0);
    bus.O_READY = 1'b1;
    send_str("a ", 200, ok);
    chk("drain accepted", ok, 1);
    exp = '{tok(8'h02, 0), tok(8'h02, 0), tok(8'h02, 0), tok(8'h02, 0), tok(8'h02, 0)};
    check_tokens("fifo", exp);

    got_q = {};
    send_str("out EOF ", 200, ok);
    send_str("c", 20, ok);
    chk("eof c refused", ok, 0);
    chk("eof I_READY", bus.I_READY, 0);
    chk("eof FOUND_EOF", found_eof, 1);
    exp = '{tok(8'h01, 0), tok(8'h0C, 0)};
    check_tokens("eof", exp);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("eofrst O_VALID", bus.O_VALID, 0);
    chk("eofrst O_KIND", bus.O_KIND, 0);
    chk("eofrst FOUND_EOF", found_eof, 0);
    chk("eofrst I_READY", bus.I_READY, 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("eofrst sticky cleared", found_eof, 0);
    chk("eofrst reopened", bus.I_READY, 1);

    // reset in the middle of a word discards it
    got_q = {};
    send_str("ab", 200, ok);
    do_reset();
    send_str("c ", 200, ok);
    exp = '{tok(8'h05, 0)};
    check_tokens("midrst", exp);

    for (int r = 0; r < 6; r++) begin
      b = {};
      repeat (16) begin
        case ($urandom_range(0, 5))
          0: piece = wl[$urandom_range(0, 8)];
          1: piece = $sformatf("%0d", $urandom_range(0, 300));
          2: piece = $sformatf("%c", ps[$urandom_range(0, 5)]);
          3: piece = "";
          4: piece = $sformatf("%c", oc[$urandom_range(0, 6)]);
          default: piece = $sformatf("0x%0h", $urandom_range(0, 300));
        endcase
        if (piece.len() == 0) b.push_back(dl[$urandom_range(0, 5)]);
        for (int i = 0; i < piece.len(); i++) b.push_back(piece[i]);
      end
      b.push_back(8'h20);
      model(b, exp);
      got_q = {};
      rdy_rand = (r % 2 == 1);
      send_bytes(b, 200, st, ok);
      chk($sformatf("rnd%0d accepted", r), ok, 1);
      check_tokens($sformatf("rnd%0d", r), exp);
      rdy_rand = 1'b0;
      bus.O_READY = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
